sdram_port_arb: RTL and testbench
=================================

// Module: sdram_port_arb
// PURPOSE
//  N-channel request/grant arbiter in front of the single-port sdram controller.
//  Generalises the fixed two-way init/run address mux to NUM_CH clients
//  (flash loader, CPU PRG, PPU CHR, ...) with per-channel enable masking,
//  per-channel read-data return and a read-timeout watchdog.
//  Sits between the client blocks and sdram (addr/rw/data_in/in_valid/busy/out_valid).
// PARAMETERS
//  NUM_CH      3    number of client channels (2..8); ch0 = highest fixed priority
//  ADDR_W      23   sdram word address width
//  DATA_W      32   sdram data width
//  RD_TIMEOUT  255  max cycles waiting for mem_out_valid before read abort (1..255)
// PORTS
//  clk          in   1               system clock (50 MHz)
//  rst_n        in   1               reset, synchronous, active-low
//  ch_en        in   NUM_CH          channel enable mask; disabled channels never win
//  ch_req       in   NUM_CH          level request, held until ch_ack
//  ch_rw        in   NUM_CH          1 = write, 0 = read, per channel
//  ch_addr      in   NUM_CH*ADDR_W   packed addresses, ch i at [i*ADDR_W +: ADDR_W]
//  ch_wdata     in   NUM_CH*DATA_W   packed write data, same packing
//  ch_ack       out  NUM_CH          1-cycle pulse: request accepted, inputs sampled
//  ch_rvalid    out  NUM_CH          1-cycle pulse: ch_rdata valid for that channel
//  ch_rdata     out  DATA_W          read data, shared by all channels
//  rd_timeout   out  1               sticky: a read was aborted by watchdog
//  owner        out  3               index of current/last granted channel
//  mem_addr     out  ADDR_W          to sdram addr
//  mem_rw       out  1               to sdram rw
//  mem_wdata    out  DATA_W          to sdram data_in
//  mem_in_valid out  1               to sdram in_valid, 1-cycle pulse
//  mem_busy     in   1               from sdram busy
//  mem_rdata    in   DATA_W          from sdram data_out
//  mem_out_valid in  1               from sdram out_valid
// BEHAVIOUR
//  Reset (rst_n low at clk edge): state IDLE; all outputs 0; rr pointer = NUM_CH-1;
//   any in-flight transaction is dropped, no ch_ack/ch_rvalid emitted afterwards.
//  FSM: IDLE -> ISSUE -> WAIT_BUSY (write) | WAIT_RD (read) -> IDLE.
//  IDLE: eligible = ch_req & ch_en; if eligible!=0 and !mem_busy, pick winner,
//   register addr/rw/wdata into mem_*, set owner, go ISSUE. Else stay.
//  ISSUE (1 cycle): mem_in_valid=1, ch_ack[owner]=1 (same cycle); mem_* stable.
//  WAIT_BUSY: ignore mem_busy in the first cycle after ISSUE; then IDLE when mem_busy=0.
//  WAIT_RD: 8-bit counter from 0; on mem_out_valid latch mem_rdata to ch_rdata,
//   pulse ch_rvalid[owner] next cycle, go IDLE. Counter reaching RD_TIMEOUT:
//   set rd_timeout, ch_rvalid[owner]=1 with ch_rdata=0, go IDLE.
//  Latency: request seen in IDLE -> ch_ack 2 cycles later; read rvalid 1 cycle after
//   mem_out_valid. Minimum back-to-back issue spacing 3 cycles.
//  mem_out_valid outside WAIT_RD: ignored. Request dropped before ack: ignored,
//   no ack. ch_en change mid-transaction: transaction completes; mask only gates
//   the next arbitration. Same channel may win consecutively if sole requester.
//  rd_timeout cleared only by reset. ch_rdata holds last value between reads.
// CONFIGURATION
//  SDRAM_ARB_RR_EN defined: round-robin; search starts at rr_ptr+1 wrapping at
//   NUM_CH-1 -> 0; rr_ptr <= winner at ISSUE.
//  SDRAM_ARB_RR_EN undefined: fixed priority, lowest eligible index wins; rr_ptr unused.
// TESTING
//  1 reset: rst_n=0 mid WAIT_RD -> next cycle all outputs 0, no ch_rvalid when mem_out_valid later.
//  2 single read: ch1 req, addr=0x00123, mem_out_valid w/ 0xA5 after 4 cycles ->
//    mem_in_valid+ch_ack[1] 2 cycles after req, ch_rvalid[1] with ch_rdata=0xA5.
//  3 contention ch0/ch1/ch2 held, fixed prio -> ack order 0,0,0...; with RR_EN -> 0,1,2,0.
//  4 masking: ch_en=3'b110, ch0 requesting alone -> no mem_in_valid for 50 cycles.
//  5 timeout: read with no mem_out_valid, RD_TIMEOUT=16 -> ch_rvalid at 16, data 0, rd_timeout=1.
//  6 write: ch2 rw=1, busy high 5 cycles -> next issue only after busy falls.

Source files
------------

// File: rtl/sdram_port_arb_if.sv
// sdram_port_arb_if
//   Bundles the client-side request/grant signals and the sdram-side command
//   signals of the sdram port arbiter into one interface.
//   Modports:
//     slave  - the arbiter view: requests and sdram status in, grants,
//              read return and sdram command out.
//     master - the environment view (clients plus sdram model), mirror of slave.
//   Signals:
//     ch_en/ch_req/ch_rw [NUM_CH]   per-channel enable, level request, 1=write
//     ch_addr/ch_wdata              packed per channel, ch i at [i*W +: W]
//     ch_ack/ch_rvalid  [NUM_CH]    1-cycle pulses toward the clients
//     ch_rdata                      shared read data
//     rd_timeout                    sticky read-abort flag
//     owner             [3]         index of current/last granted channel
//     mem_addr/mem_rw/mem_wdata/mem_in_valid   command to sdram
//     mem_busy/mem_rdata/mem_out_valid         status from sdram
interface sdram_port_arb_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic [NUM_CH-1:0]        ch_en;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_rw;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_ack;
  logic [NUM_CH-1:0]        ch_rvalid;
  logic [DATA_W-1:0]        ch_rdata;
  logic                     rd_timeout;
  logic [2:0]               owner;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_rw;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     mem_in_valid;
  logic                     mem_busy;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     mem_out_valid;

  modport slave (
    input  ch_en, ch_req, ch_rw, ch_addr, ch_wdata,
    input  mem_busy, mem_rdata, mem_out_valid,
    output ch_ack, ch_rvalid, ch_rdata, rd_timeout, owner,
    output mem_addr, mem_rw, mem_wdata, mem_in_valid
  );

  modport master (
    output ch_en, ch_req, ch_rw, ch_addr, ch_wdata,
    output mem_busy, mem_rdata, mem_out_valid,
    input  ch_ack, ch_rvalid, ch_rdata, rd_timeout, owner,
    input  mem_addr, mem_rw, mem_wdata, mem_in_valid
  );
endinterface

// File: rtl/sdram_port_arb.sv
// sdram_port_arb
//   N-channel request/grant arbiter in front of the single-port sdram
//   controller. Enabled, requesting channels compete for the sdram; the winner's
//   address/rw/data are registered onto the sdram command port, the channel is
//   acknowledged, and read data is returned to it (or zero plus a sticky
//   rd_timeout flag if the sdram never answers).
//   Ports:
//     clk    - system clock
//     rst_n  - synchronous, active-low reset
//     bus    - sdram_port_arb_if.slave (client and sdram signals)
//   Configuration:
//     SDRAM_ARB_RR_EN defined   - round-robin arbitration starting after the
//                                 last winner
//     SDRAM_ARB_RR_EN undefined - fixed priority, lowest eligible index wins
module sdram_port_arb #(
  parameter int NUM_CH     = 3,
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 32,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sdram_port_arb_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_RD} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [NUM_CH-1:0]   w_eligible;
  logic                w_found;
  logic [2:0]          w_winner;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic                w_sel_rw;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [NUM_CH-1:0]   w_owner_oh;
  logic                w_grant;
  logic                w_issue;
  logic                w_rd_data;
  logic                w_rd_abort;
  logic [7:0]          r_cnt;
  logic [NUM_CH-1:0]   r_ack;
  logic [NUM_CH-1:0]   r_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_timeout;
  logic [2:0]          r_owner;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_rw;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_mem_in_valid;
`ifdef SDRAM_ARB_RR_EN
  logic [2:0]          r_rr_ptr;
  int                  w_dist;
  int                  w_best;
`endif

  assign w_eligible = bus.ch_req & bus.ch_en;

  // Winner selection. Round-robin ranks each eligible channel by its distance
  // past the last winner so every index is a constant loop bound.
  always_comb begin
    w_found  = 1'b0;
    w_winner = 3'd0;
`ifdef SDRAM_ARB_RR_EN
    w_best = NUM_CH;
    w_dist = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_dist = (i + NUM_CH - 1 - int'(r_rr_ptr)) % NUM_CH;
      if (w_eligible[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        w_winner = 3'(i);
        w_found  = 1'b1;
      end
    end
`else
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_winner = 3'(i);
        w_found  = 1'b1;
      end
    end
`endif
  end

  // Pick the winning channel's command fields out of the packed buses.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_rw    = 1'b0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_winner == 3'(i)) begin
        w_sel_addr  = bus.ch_addr[i*ADDR_W +: ADDR_W];
        w_sel_rw    = bus.ch_rw[i];
        w_sel_wdata = bus.ch_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_owner_oh = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_owner_oh[i] = (r_owner == 3'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next state and single-cycle control strobes. WAIT_BUSY uses r_cnt==0 to
  // skip the first cycle, where mem_busy has not yet reacted to in_valid.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_issue      = 1'b0;
    w_rd_data    = 1'b0;
    w_rd_abort   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found && !bus.mem_busy) begin
          w_grant      = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        w_issue      = 1'b1;
        w_next_state = r_mem_rw ? WAIT_BUSY : WAIT_RD;
      end
      WAIT_BUSY: begin
        if ((r_cnt != 8'd0) && !bus.mem_busy) w_next_state = IDLE;
      end
      WAIT_RD: begin
        if (bus.mem_out_valid) begin
          w_rd_data    = 1'b1;
          w_next_state = IDLE;
        end else if ((r_cnt + 8'd1) == 8'(RD_TIMEOUT)) begin
          w_rd_abort   = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Registered datapath: command latch on grant, ack/in_valid pulses when
  // leaving ISSUE, read return or watchdog abort when leaving WAIT_RD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt          <= 8'd0;
      r_ack          <= '0;
      r_rvalid       <= '0;
      r_rdata        <= '0;
      r_timeout      <= 1'b0;
      r_owner        <= 3'd0;
      r_mem_addr     <= '0;
      r_mem_rw       <= 1'b0;
      r_mem_wdata    <= '0;
      r_mem_in_valid <= 1'b0;
    end else begin
      r_ack          <= '0;
      r_rvalid       <= '0;
      r_mem_in_valid <= 1'b0;
      if (w_grant) begin
        r_mem_addr  <= w_sel_addr;
        r_mem_rw    <= w_sel_rw;
        r_mem_wdata <= w_sel_wdata;
        r_owner     <= w_winner;
      end
      if (w_issue) begin
        r_mem_in_valid <= 1'b1;
        r_ack          <= w_owner_oh;
      end
      if (w_issue)                                    r_cnt <= 8'd0;
      else if (r_state == WAIT_BUSY && r_cnt == 8'd0) r_cnt <= 8'd1;
      else if (r_state == WAIT_RD)                    r_cnt <= r_cnt + 8'd1;
      if (w_rd_data) begin
        r_rdata  <= bus.mem_rdata;
        r_rvalid <= w_owner_oh;
      end
      if (w_rd_abort) begin
        r_rdata   <= '0;
        r_rvalid  <= w_owner_oh;
        r_timeout <= 1'b1;
      end
    end
  end

`ifdef SDRAM_ARB_RR_EN
  // Remember the last issued channel so the next search starts just after it.
  always_ff @(posedge clk) begin
    if (!rst_n)       r_rr_ptr <= 3'(NUM_CH - 1);
    else if (w_issue) r_rr_ptr <= r_owner;
  end
`endif

  assign bus.ch_ack       = r_ack;
  assign bus.ch_rvalid    = r_rvalid;
  assign bus.ch_rdata     = r_rdata;
  assign bus.rd_timeout   = r_timeout;
  assign bus.owner        = r_owner;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_rw       = r_mem_rw;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.mem_in_valid = r_mem_in_valid;

endmodule

// File: tb/tb_sdram_port_arb.sv
// tb_sdram_port_arb
//   Directed bench for sdram_port_arb (3 channels, RD_TIMEOUT=16). Inputs are
//   driven and outputs sampled on the falling clock edge; the sdram side is
//   played by the bench itself.
module tb_sdram_port_arb;
  localparam int NUM_CH     = 3;
  localparam int ADDR_W     = 23;
  localparam int DATA_W     = 32;
  localparam int RD_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  sdram_port_arb_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_port_arb #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Hard stop in case something blocks forever.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idleInputs();
    bus.ch_en         = 3'b111;
    bus.ch_req        = 3'b000;
    bus.ch_rw         = 3'b000;
    bus.ch_addr       = '0;
    bus.ch_wdata      = '0;
    bus.mem_busy      = 1'b0;
    bus.mem_rdata     = '0;
    bus.mem_out_valid = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    idleInputs();
    tick(2);
    rst_n = 1'b1;
  endtask

  // Counts falling edges until mem_in_valid is seen, giving up at limit.
  task automatic waitInValid(input int limit, output int cycles);
    cycles = 0;
    while (bus.mem_in_valid !== 1'b1 && cycles < limit) begin
      tick(1);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idleInputs();
    bus.ch_req = 3'b111;
    tick(2);
    total++; if (bus.ch_ack !== 3'b000) begin bad++; $display("[TB] FAIL reset_ack: got %b want 000", bus.ch_ack); end
    total++; if (bus.ch_rvalid !== 3'b000) begin bad++; $display("[TB] FAIL reset_rvalid: got %b want 000", bus.ch_rvalid); end
    total++; if (bus.ch_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 0", bus.ch_rdata); end
    total++; if (bus.rd_timeout !== 1'b0) begin bad++; $display("[TB] FAIL reset_timeout: got %b want 0", bus.rd_timeout); end
    total++; if (bus.owner !== 3'd0) begin bad++; $display("[TB] FAIL reset_owner: got %0d want 0", bus.owner); end
    total++; if (bus.mem_addr !== 23'h0) begin bad++; $display("[TB] FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    total++; if (bus.mem_rw !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_rw: got %b want 0", bus.mem_rw); end
    total++; if (bus.mem_wdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
    total++; if (bus.mem_in_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_valid: got %b want 0", bus.mem_in_valid); end
    bus.ch_req = 3'b000;
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_single_read();
    doReset();
    bus.ch_addr = {23'h0, 23'h00123, 23'h0};
    bus.ch_req  = 3'b010;
    tick(1);
    total++; if (bus.mem_in_valid !== 1'b0) begin bad++; $display("[TB] FAIL read_early_issue: got %b want 0", bus.mem_in_valid); end
    tick(1);
    total++; if (bus.mem_in_valid !== 1'b1) begin bad++; $display("[TB] FAIL read_in_valid: got %b want 1", bus.mem_in_valid); end
    total++; if (bus.ch_ack !== 3'b010) begin bad++; $display("[TB] FAIL read_ack: got %b want 010", bus.ch_ack); end
    total++; if (bus.owner !== 3'd1) begin bad++; $display("[TB] FAIL read_owner: got %0d want 1", bus.owner); end
    total++; if (bus.mem_addr !== 23'h00123) begin bad++; $display("[TB] FAIL read_addr: got %h want 00123", bus.mem_addr); end
    total++; if (bus.mem_rw !== 1'b0) begin bad++; $display("[TB] FAIL read_rw: got %b want 0", bus.mem_rw); end
    bus.ch_req = 3'b000;
    tick(1);
    total++; if (bus.ch_ack !== 3'b000 || bus.mem_in_valid !== 1'b0) begin bad++; $display("[TB] FAIL read_pulse_width: got ack=%b iv=%b want 000/0", bus.ch_ack, bus.mem_in_valid); end
    tick(3);
    bus.mem_rdata     = 32'h000000A5;
    bus.mem_out_valid = 1'b1;
    tick(1);
    bus.mem_out_valid = 1'b0;
    total++; if (bus.ch_rvalid !== 3'b010) begin bad++; $display("[TB] FAIL read_rvalid: got %b want 010", bus.ch_rvalid); end
    total++; if (bus.ch_rdata !== 32'h000000A5) begin bad++; $display("[TB] FAIL read_rdata: got %h want a5", bus.ch_rdata); end
    tick(1);
    total++; if (bus.ch_rvalid !== 3'b000 || bus.ch_rdata !== 32'h000000A5) begin bad++; $display("[TB] FAIL read_hold: got rv=%b d=%h want 000/a5", bus.ch_rvalid, bus.ch_rdata); end
  endtask

  task automatic test_contention();
    logic [2:0]  expAck [4];
    logic [22:0] expAddr [4];
    int          cyc;
`ifdef SDRAM_ARB_RR_EN
    expAck  = '{3'b001, 3'b010, 3'b100, 3'b001};
    expAddr = '{23'h100, 23'h200, 23'h300, 23'h100};
`else
    expAck  = '{3'b001, 3'b001, 3'b001, 3'b001};
    expAddr = '{23'h100, 23'h100, 23'h100, 23'h100};
`endif
    doReset();
    bus.ch_addr = {23'h300, 23'h200, 23'h100};
    bus.ch_req  = 3'b111;
    for (int t = 0; t < 4; t++) begin
      waitInValid(10, cyc);
      total++; if (cyc !== 2) begin bad++; $display("[TB] FAIL contend_spacing[%0d]: got %0d want 2", t, cyc); end
      total++; if (bus.ch_ack !== expAck[t]) begin bad++; $display("[TB] FAIL contend_ack[%0d]: got %b want %b", t, bus.ch_ack, expAck[t]); end
      total++; if (bus.mem_addr !== expAddr[t]) begin bad++; $display("[TB] FAIL contend_addr[%0d]: got %h want %h", t, bus.mem_addr, expAddr[t]); end
      bus.mem_rdata     = 32'h1000 + t;
      bus.mem_out_valid = 1'b1;
      tick(1);
      bus.mem_out_valid = 1'b0;
      total++; if (bus.ch_rvalid !== expAck[t]) begin bad++; $display("[TB] FAIL contend_rvalid[%0d]: got %b want %b", t, bus.ch_rvalid, expAck[t]); end
      total++; if (bus.ch_rdata !== 32'h1000 + t) begin bad++; $display("[TB] FAIL contend_rdata[%0d]: got %h want %h", t, bus.ch_rdata, 32'h1000 + t); end
    end
    bus.ch_req = 3'b000;
  endtask

  task automatic test_masking();
    int seen;
    int cyc;
    doReset();
    bus.ch_en   = 3'b110;
    bus.ch_addr = {23'h0, 23'h222, 23'h111};
    bus.ch_req  = 3'b001;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (bus.mem_in_valid !== 1'b0 || bus.ch_ack !== 3'b000) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("[TB] FAIL mask_blocked: got %0d issues want 0", seen); end
    bus.ch_req = 3'b011;
    waitInValid(10, cyc);
    total++; if (cyc !== 2) begin bad++; $display("[TB] FAIL mask_latency: got %0d want 2", cyc); end
    total++; if (bus.ch_ack !== 3'b010) begin bad++; $display("[TB] FAIL mask_winner: got %b want 010", bus.ch_ack); end
    total++; if (bus.mem_addr !== 23'h222) begin bad++; $display("[TB] FAIL mask_addr: got %h want 222", bus.mem_addr); end
    bus.ch_req = 3'b000;
  endtask

  task automatic test_timeout();
    int cyc;
    int wait_cnt;
    doReset();
    bus.ch_addr = {23'h0, 23'h0, 23'h4444};
    bus.ch_req  = 3'b001;
    waitInValid(10, cyc);
    bus.ch_req        = 3'b000;
    bus.mem_rdata     = 32'h55;
    bus.mem_out_valid = 1'b1;
    tick(1);
    bus.mem_out_valid = 1'b0;
    total++; if (bus.ch_rdata !== 32'h55) begin bad++; $display("[TB] FAIL tmo_pre_rdata: got %h want 55", bus.ch_rdata); end
    bus.ch_req = 3'b001;
    waitInValid(10, cyc);
    bus.ch_req = 3'b000;
    wait_cnt = 0;
    while (bus.ch_rvalid === 3'b000 && wait_cnt < 40) begin
      tick(1);
      wait_cnt++;
    end
    total++; if (wait_cnt !== 16) begin bad++; $display("[TB] FAIL tmo_cycles: got %0d want 16", wait_cnt); end
    total++; if (bus.ch_rvalid !== 3'b001) begin bad++; $display("[TB] FAIL tmo_rvalid: got %b want 001", bus.ch_rvalid); end
    total++; if (bus.ch_rdata !== 32'h0) begin bad++; $display("[TB] FAIL tmo_rdata: got %h want 0", bus.ch_rdata); end
    total++; if (bus.rd_timeout !== 1'b1) begin bad++; $display("[TB] FAIL tmo_flag: got %b want 1", bus.rd_timeout); end
    bus.ch_req = 3'b001;
    waitInValid(10, cyc);
    bus.ch_req        = 3'b000;
    bus.mem_rdata     = 32'h66;
    bus.mem_out_valid = 1'b1;
    tick(1);
    bus.mem_out_valid = 1'b0;
    total++; if (bus.rd_timeout !== 1'b1 || bus.ch_rdata !== 32'h66) begin bad++; $display("[TB] FAIL tmo_sticky: got flag=%b d=%h want 1/66", bus.rd_timeout, bus.ch_rdata); end
  endtask

  task automatic test_write();
    int cyc;
    int early;
    doReset();
    bus.ch_rw    = 3'b100;
    bus.ch_addr  = {23'h7ABCD, 23'h0, 23'h0011};
    bus.ch_wdata = {32'hDEADBEEF, 32'h0, 32'h0};
    bus.ch_req   = 3'b100;
    waitInValid(10, cyc);
    total++; if (bus.ch_ack !== 3'b100) begin bad++; $display("[TB] FAIL wr_ack: got %b want 100", bus.ch_ack); end
    total++; if (bus.mem_rw !== 1'b1) begin bad++; $display("[TB] FAIL wr_rw: got %b want 1", bus.mem_rw); end
    total++; if (bus.mem_wdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL wr_wdata: got %h want deadbeef", bus.mem_wdata); end
    total++; if (bus.mem_addr !== 23'h7ABCD) begin bad++; $display("[TB] FAIL wr_addr: got %h want 7abcd", bus.mem_addr); end
    bus.ch_req   = 3'b001;
    bus.mem_busy = 1'b1;
    early = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (bus.mem_in_valid !== 1'b0) early++;
    end
    bus.mem_busy = 1'b0;
    waitInValid(10, cyc);
    total++; if (early !== 0) begin bad++; $display("[TB] FAIL wr_busy_block: got %0d issues want 0", early); end
    total++; if (cyc !== 3) begin bad++; $display("[TB] FAIL wr_after_busy: got %0d want 3", cyc); end
    total++; if (bus.ch_ack !== 3'b001 || bus.mem_rw !== 1'b0 || bus.mem_addr !== 23'h0011) begin bad++; $display("[TB] FAIL wr_next: got ack=%b rw=%b a=%h want 001/0/0011", bus.ch_ack, bus.mem_rw, bus.mem_addr); end
    bus.ch_req = 3'b000;
  endtask

  task automatic test_reset_mid_read();
    int cyc;
    int seen;
    doReset();
    bus.ch_addr = {23'h0, 23'h00123, 23'h0};
    bus.ch_req  = 3'b010;
    waitInValid(10, cyc);
    bus.ch_req = 3'b000;
    tick(1);
    rst_n = 1'b0;
    tick(1);
    total++; if (bus.mem_addr !== 23'h0 || bus.owner !== 3'd0 || bus.mem_in_valid !== 1'b0 || bus.ch_ack !== 3'b000) begin bad++; $display("[TB] FAIL midrst_outputs: got a=%h o=%0d iv=%b ack=%b want 0/0/0/000", bus.mem_addr, bus.owner, bus.mem_in_valid, bus.ch_ack); end
    rst_n             = 1'b1;
    bus.mem_rdata     = 32'h77;
    bus.mem_out_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (bus.ch_rvalid !== 3'b000) seen++;
    end
    bus.mem_out_valid = 1'b0;
    total++; if (seen !== 0) begin bad++; $display("[TB] FAIL midrst_rvalid: got %0d pulses want 0", seen); end
    total++; if (bus.ch_rdata !== 32'h0) begin bad++; $display("[TB] FAIL midrst_rdata: got %h want 0", bus.ch_rdata); end
  endtask

  initial begin
    rst_n = 1'b0;
    idleInputs();
    test_reset();
    test_single_read();
    test_contention();
    test_masking();
    test_timeout();
    test_write();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
